// File: rtl/div_pkg.sv
// Shared types for the iterative unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int N = 16
) (
  input  logic [N:0]   rem_in,
  input  logic         dvd_bit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N:0]   dsr_ext;
  logic         ge;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    dsr_ext = {1'b0, divisor};
    // the top bit is a carry-out of the shift; if set the value certainly exceeds the divisor
    ge      = shifted[N+1] | (shifted[N:0] >= dsr_ext);
    q_bit   = ge;
    rem_out = ge ? (shifted[N:0] - dsr_ext) : shifted[N:0];
  end

endmodule

// File: rtl/div.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | shifting/subtracting, one quotient bit per edge
// DONE  | quo/rem valid for one cycle; start may be accepted here
module div
  import div_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem,
  output logic         dbz
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N-1);

  div_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]   prem_q, prem_d;
  logic [N-1:0] dvd_q, dvd_d;
  logic [N-1:0] dsr_q, dsr_d;
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;

  logic [N:0]   step_rem;
  logic         step_q;
  logic         accept;

  div_step #(.N(N)) u_step (
    .rem_in  (prem_q),
    .dvd_bit (dvd_q[N-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    accept  = start && (state_q != CALC);

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
          dvd_d  = inp1;
          dsr_d  = inp2;
          prem_d = '0;
          cnt_d  = '0;
          if (inp2 == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = inp1;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        // dividend register doubles as the quotient accumulator
        prem_d = step_rem;
        dvd_d  = {dvd_q[N-2:0], step_q};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          quo_d   = {dvd_q[N-2:0], step_q};
          rem_d   = step_rem[N-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div.sv
// Directed-vector and corner-case bench for the iterative divider.
module tb_div;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] inp1 = '0;
  logic [N-1:0] inp2 = '0;
  logic         busy, done, dbz;
  logic [N-1:0] quo, rem;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  div #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .inp1  (inp1),
    .inp2  (inp2),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called on the negedge right after the accepting edge; returns on the negedge where done is seen.
  task automatic wait_done(output int lat, output int bcnt, output int chg, output logic ok);
    logic [N-1:0] q0, r0;
    q0 = quo; r0 = rem;
    lat = 0; bcnt = 0; chg = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (quo !== q0 || rem !== r0) chg++;
      @(negedge clk);
      lat++;
    end
    ok = done;
  endtask

  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bcnt, output int chg, output logic ok);
    @(negedge clk);
    inp1 = a; inp2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt, chg, ok);
  endtask

  initial begin
    int lat, bcnt, chg, ndone;
    logic ok;
    logic [31:0] ra, rb;

    vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0, N};
    vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,    1'b0, N};
    vecs[2]  = '{16'd3,     16'd10,     16'd0,      16'd3,    1'b0, N};
    vecs[3]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,    1'b1, 0};
    vecs[4]  = '{16'd9,     16'd3,      16'd3,      16'd0,    1'b0, N};
    vecs[5]  = '{16'd200,   16'd9,      16'd22,     16'd2,    1'b0, N};
    vecs[6]  = '{16'd0,     16'd5,      16'd0,      16'd0,    1'b0, N};
    vecs[7]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0, N};
    vecs[8]  = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, 1'b1, 0};
    vecs[9]  = '{16'd65535, 16'd256,    16'd255,    16'd255,  1'b0, N};
    vecs[10] = '{16'd40000, 16'd123,    16'd325,    16'd25,   1'b0, N};
    vecs[11] = '{16'h8000,  16'hFFFF,   16'd0,      16'h8000, 1'b0, N};

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst quo", quo, 0);
    chk("rst rem", rem, 0);
    chk("rst dbz", dbz, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat, bcnt, chg, ok);
      chk($sformatf("v%0d timeout", i), ok, 1);
      chk($sformatf("v%0d quo", i), quo, vecs[i].q);
      chk($sformatf("v%0d rem", i), rem, vecs[i].r);
      chk($sformatf("v%0d dbz", i), dbz, vecs[i].z);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d busy cycles", i), bcnt, vecs[i].lat);
      chk($sformatf("v%0d stable in calc", i), chg, 0);
      @(negedge clk);
      chk($sformatf("v%0d done pulse", i), done, 0);
      chk($sformatf("v%0d idle busy", i), busy, 0);
    end

    // start during CALC must be ignored
    @(negedge clk);
    inp1 = 16'd100; inp2 = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    inp1 = 16'd50; inp2 = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt, chg, ok);
    chk("ign timeout", ok, 1);
    chk("ign latency", lat + 4, N);
    chk("ign quo", quo, 14);
    chk("ign rem", rem, 2);
    ndone = 0;
    @(negedge clk);
    repeat (40) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ign extra done", ndone, 0);

    // reset in the middle of CALC
    @(negedge clk);
    inp1 = 16'd100; inp2 = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid busy pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst quo", quo, 0);
    chk("mid rst rem", rem, 0);
    chk("mid rst dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("post rst done", ndone, 0);
    // release and start together: first edge after release must accept
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; inp1 = 16'd200; inp2 = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first edge accept", busy, 1);
    wait_done(lat, bcnt, chg, ok);
    chk("200/9 latency", lat, N);
    chk("200/9 quo", quo, 22);
    chk("200/9 rem", rem, 2);

    // back-to-back with start held through DONE
    @(negedge clk);
    inp1 = 16'd100; inp2 = 16'd7; start = 1'b1;
    @(negedge clk);
    inp1 = 16'd9; inp2 = 16'd3;
    wait_done(lat, bcnt, chg, ok);
    chk("b2b1 latency", lat, N);
    chk("b2b1 quo", quo, 14);
    chk("b2b1 rem", rem, 2);
    @(negedge clk);
    start = 1'b0;
    chk("b2b2 accepted", busy, 1);
    wait_done(lat, bcnt, chg, ok);
    chk("b2b2 latency", lat, N);
    chk("b2b2 quo", quo, 3);
    chk("b2b2 rem", rem, 0);
    chk("b2b2 dbz", dbz, 0);

    // random operands against the division identity
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom_range(0, 65535);
      if (i % 16 == 0)     rb = 0;
      else if (i % 3 == 0) rb = $urandom_range(1, 15);
      else                 rb = $urandom_range(1, 65535);
      run_div(ra[15:0], rb[15:0], lat, bcnt, chg, ok);
      chk("rnd timeout", ok, 1);
      if (rb == 0) begin
        chk("rnd dbz quo", quo, 16'hFFFF);
        chk("rnd dbz rem", rem, ra);
        chk("rnd dbz flag", dbz, 1);
      end else begin
        chk("rnd identity", 32'(quo) * rb + 32'(rem), ra);
        chk("rnd rem<div", (32'(rem) < rb), 1);
        chk("rnd dbz clr", dbz, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
